// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand request handshake plus result handshake.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       Op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;

    modport master (
        output in_valid, a, b, Op, out_ready,
        input  in_ready, out_valid, res, flags
    );

    modport slave (
        input  in_valid, a, b, Op, out_ready,
        output in_ready, out_valid, res, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/logic/shift ops, optional iterative shift-add MUL.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise Op 7 returns 0 with Z set.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             is_mul;
    logic             mul_last;
    logic [SW-1:0]    sh;
    logic [WIDTH:0]   add_full, sub_full, shl_full, shr_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [3:0]       alu_flags;

    assign accept = bus.in_valid && (state == IDLE);

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [SW-1:0]      cnt;

    assign is_mul   = (bus.Op == 3'd7);
    assign mul_last = (state == BUSY) && (cnt == SW'(WIDTH - 1));
    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept && is_mul) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            cnt    <= '0;
        end else if (state == BUSY) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_last = 1'b0;
`endif

    // Shifts run one bit wider so the last bit shifted out lands in the extra bit.
    always_comb begin
        sh       = bus.b[SW-1:0];
        add_full = {1'b0, bus.a} + {1'b0, bus.b};
        sub_full = {1'b0, bus.a} - {1'b0, bus.b};
        shl_full = {1'b0, bus.a} << sh;
        shr_full = {bus.a, 1'b0} >> sh;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (bus.Op)
            3'd0: begin
                alu_res = add_full[WIDTH-1:0];
                alu_c   = add_full[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'd1: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_c   = sub_full[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'd2: alu_res = bus.a & bus.b;
            3'd3: alu_res = bus.a | bus.b;
            3'd4: alu_res = bus.a ^ bus.b;
            3'd5: begin
                alu_res = shl_full[WIDTH-1:0];
                alu_c   = shl_full[WIDTH];
            end
            3'd6: begin
                alu_res = shr_full[WIDTH:1];
                alu_c   = shr_full[0];
            end
            default: alu_res = '0;
        endcase
        alu_flags = {alu_v, alu_res[WIDTH-1], alu_c, (alu_res == '0)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = is_mul ? BUSY : DONE;
            end
            BUSY: if (mul_last) state_nxt = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // res/flags only load on accept or MUL completion, so they hold through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res   <= '0;
            bus.flags <= '0;
        end else if (accept && !is_mul) begin
            bus.res   <= alu_res;
            bus.flags <= alu_flags;
`ifdef ALU_SEQ_MUL_EN
        end else if (mul_last) begin
            bus.res   <= acc_nxt[WIDTH-1:0];
            bus.flags <= {1'b0, acc_nxt[WIDTH-1], |acc_nxt[2*WIDTH-1:WIDTH], (acc_nxt[WIDTH-1:0] == '0)};
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for every op plus backpressure and reset corner cases.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(16)) bus ();
    alu_seq #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                          output logic [15:0] r, output logic [3:0] f, output int lat,
                          output int rdy_busy);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.Op = op; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        rdy_busy = 0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_busy++;
            @(posedge clk);
            #1;
            lat++;
        end
        r = bus.res;
        f = bus.flags;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] r;
        logic [3:0]  f;
        int          lat, rb;

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.Op = '0; bus.out_ready = 1'b1;

        vt[0]  = '{16'h006A, 16'h003B, 3'd0, 16'h00A5, 4'b0000, 0};
        vt[1]  = '{16'h006A, 16'h003B, 3'd1, 16'h002F, 4'b0000, 0};
        vt[2]  = '{16'h006A, 16'h003B, 3'd2, 16'h002A, 4'b0000, 0};
        vt[3]  = '{16'h006A, 16'h003B, 3'd3, 16'h007B, 4'b0000, 0};
        vt[4]  = '{16'h006A, 16'h003B, 3'd4, 16'h0051, 4'b0000, 0};
        vt[5]  = '{16'h006A, 16'h003B, 3'd5, 16'h5000, 4'b0010, 0};
        vt[6]  = '{16'h006A, 16'h003B, 3'd6, 16'h0000, 4'b0001, 0};
        vt[7]  = '{16'h7FFF, 16'h0001, 3'd0, 16'h8000, 4'b1100, 0};
        vt[8]  = '{16'h0000, 16'h0001, 3'd1, 16'hFFFF, 4'b0110, 0};
        vt[9]  = '{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 4'b0011, 0};
        vt[10] = '{16'h8000, 16'h0001, 3'd1, 16'h7FFF, 4'b1000, 0};
        vt[11] = '{16'h1234, 16'h0010, 3'd5, 16'h1234, 4'b0000, 0};
        vt[12] = '{16'h8001, 16'h0001, 3'd6, 16'h4000, 4'b0010, 0};
`ifdef ALU_SEQ_MUL_EN
        vt[13] = '{16'h006A, 16'h003B, 3'd7, 16'h186E, 4'b0000, 16};
        vt[14] = '{16'hFFFF, 16'h0002, 3'd7, 16'hFFFE, 4'b0110, 16};
`else
        vt[13] = '{16'h006A, 16'h003B, 3'd7, 16'h0000, 4'b0001, 0};
        vt[14] = '{16'hFFFF, 16'h0002, 3'd7, 16'h0000, 4'b0001, 0};
`endif

        // reset state
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_res", 32'(bus.res), 32'd0);
        chk("rst_flags", 32'(bus.flags), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].op, r, f, lat, rb);
            chk($sformatf("v%0d_res", i), 32'(r), 32'(vt[i].r));
            chk($sformatf("v%0d_flags", i), 32'(f), 32'(vt[i].f));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_busy_rdy", i), 32'(rb), 32'd0);
            chk($sformatf("v%0d_idle", i), 32'({bus.out_valid, bus.in_ready}), 32'b01);
        end

        // backpressure: result must hold and new requests are ignored
        @(negedge clk);
        bus.a = 16'd3; bus.b = 16'd4; bus.Op = 3'd0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.a = 16'hFFFF; bus.b = 16'h0F0F; bus.Op = 3'd2;
        chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_hold", c), 32'({bus.out_valid, bus.in_ready, bus.flags, bus.res}),
                32'({1'b1, 1'b0, 4'b0000, 16'h0007}));
        end
        @(negedge clk);
        bus.out_ready = 1'b1; bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_release", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        chk("bp_res_kept", 32'(bus.res), 32'h0007);

        // reset while busy (or while holding a result without the multiplier)
        @(negedge clk);
        bus.a = 16'd3; bus.b = 16'd5; bus.in_valid = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        bus.Op = 3'd7; bus.out_ready = 1'b1;
`else
        bus.Op = 3'd0; bus.out_ready = 1'b0;
`endif
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
`ifdef ALU_SEQ_MUL_EN
        chk("mid_busy_rdy", 32'({bus.out_valid, bus.in_ready}), 32'b00);
`else
        chk("mid_done_res", 32'(bus.res), 32'h0008);
`endif
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_res", 32'(bus.res), 32'd0);
        chk("arst_flags", 32'(bus.flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        run_op(16'd1, 16'd1, 3'd0, r, f, lat, rb);
        chk("post_rst_res", 32'(r), 32'h0002);
        chk("post_rst_flags", 32'(f), 32'h0);
        chk("post_rst_lat", 32'(lat), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits (power of 2, >= 4).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request.
REQ-005 SHALL have port: in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port: a  input  WIDTH  operand A.
REQ-007 SHALL have port: b  input  WIDTH  operand B; shift amount is b[$clog2(WIDTH)-1:0].
REQ-008 SHALL have port: Op  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 MUL.
REQ-009 SHALL have port: out_valid  output  1  res/flags valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: res  output  WIDTH  registered result.
REQ-012 SHALL have port: flags  output  4  {V, N, C, Z}, registered with res.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL accept a request on a rising edge with in_valid & in_ready, capturing a, b, Op; inputs are ignored at all other times.
REQ-015 SHALL, for Op 0-6, go IDLE->DONE on the accept edge with res/flags loaded (out_valid high the following cycle; latency 1).
REQ-016 SHALL, for Op 7, go IDLE->BUSY and perform iterative shift-add over exactly WIDTH cycles (counter 0..WIDTH-1), then BUSY->DONE; out_valid rises on edge accept+WIDTH.
REQ-017 SHALL keep res, flags, out_valid stable in DONE until an edge with out_ready=1, then go DONE->IDLE with out_valid low next cycle.
REQ-018 SHALL compute all arithmetic modulo 2^WIDTH; MUL result = low WIDTH bits of the unsigned 2*WIDTH product.
REQ-019 SHALL set Z = (res == 0) and N = res[WIDTH-1] for all ops.
REQ-020 SHALL set C: ADD carry-out; SUB borrow (a < b unsigned); SHL/SHR last bit shifted out (0 if shift amount 0); MUL 1 if product high half nonzero; logic ops 0.
REQ-021 SHALL set V: signed overflow for ADD/SUB; 0 for all other ops.
REQ-022 SHALL treat shift amount modulo WIDTH (low $clog2(WIDTH) bits of b only).
REQ-023 SHALL hold in_valid while BUSY/DONE without effect; requests are never queued.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state IDLE, counter 0, res 0, flags 0, out_valid 0.
REQ-025 SHALL abandon any in-flight MUL or undelivered result on reset; in_ready is 1 from the first cycle after rst_n release.

Configuration
REQ-026 SHALL, when macro ALU_SEQ_MUL_EN is defined, implement Op 7 per REQ-016/018/020.
REQ-027 SHALL, without ALU_SEQ_MUL_EN, omit the multiplier and counter; Op 7 completes in 1 cycle like Op 0-6 with res 0 and flags {V,N,C,Z} = 4'b0001.

Verification
REQ-028 SHALL cover: WIDTH=16, a=0x006A, b=0x003B, Op 0..6 with out_ready=1 -> res 0x00A5, 0x002F, 0x002A, 0x007B, 0x0051, 0x5000 (C=1), 0x0000 (Z=1, C=0), each out_valid one cycle after accept.
REQ-029 SHALL cover: a=0x7FFF, b=0x0001, ADD -> res 0x8000, V=1, N=1, C=0, Z=0; a=0x0000, b=0x0001, SUB -> res 0xFFFF, C=1, N=1, V=0.
REQ-030 SHALL cover (MUL_EN): a=0x006A, b=0x003B, Op 7 -> res 0x186E, C=0, out_valid on edge accept+16, in_ready 0 throughout BUSY; a=0xFFFF, b=0x0002 -> res 0xFFFE, C=1.
REQ-031 SHALL cover: out_ready held 0 for 5 cycles after result -> res/flags/out_valid constant, in_ready 0, new in_valid ignored; out_ready 1 -> IDLE next cycle.
REQ-032 SHALL cover: rst_n pulsed low during BUSY cycle 5 of a MUL -> out_valid 0, res 0, flags 0 immediately; in_ready 1 after release; next ADD 1+1 -> res 0x0002.
REQ-033 SHALL cover (no MUL_EN): Op 7 with any operands -> res 0x0000, flags 4'b0001, latency 1.
